// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes, FSM states and the iteration counter sizing.
package mdu_pkg;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10
   } mdu_state_e;

   function automatic int cnt_bits(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// Conditional two's-complement: res = neg ? -val : val.
// Used for operand magnitudes and for result sign correction.
module mdu_cond_neg #(
   parameter int W = 32
) (
   input  logic [W-1:0] val,
   input  logic         neg,
   output logic [W-1:0] res
);

   assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit for the EXE stage.
// Works on magnitudes, then fixes signs in a single FIX cycle.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             div_by_zero
);

   localparam int W  = WIDTH;
   localparam int CW = cnt_bits(WIDTH);

   mdu_state_e      state;
   mdu_op_e         op_q;
   logic            sign_a;
   logic            sign_b;
   logic            dz;
   logic [CW-1:0]   count;
   logic [W-1:0]    opb;
   logic [2*W-1:0]  acc;

   logic            signed_in;
   logic            is_div;
   logic [W-1:0]    mag_a;
   logic [W-1:0]    mag_b;
   logic [W:0]      sum;
   logic [W:0]      shifted;
   logic [W+1:0]    diff;
   logic            ge;
   logic [2*W-1:0]  mul_next;
   logic [2*W-1:0]  div_next;
   logic [2*W-1:0]  prod;
   logic [W-1:0]    quo;
   logic [W-1:0]    rem;
   logic [W-1:0]    res_lo;
   logic [W-1:0]    res_hi;

   assign signed_in = !op[0];
   assign is_div    = op_q inside {MDU_DIV, MDU_DIVU};
   assign busy      = (state != S_IDLE);

   mdu_cond_neg #(.W(W)) u_abs_a (
      .val (rs_data),
      .neg (signed_in && rs_data[W-1]),
      .res (mag_a)
   );

   mdu_cond_neg #(.W(W)) u_abs_b (
      .val (rt_data),
      .neg (signed_in && rt_data[W-1]),
      .res (mag_b)
   );

   mdu_cond_neg #(.W(2*W)) u_fix_prod (
      .val (acc),
      .neg (sign_a ^ sign_b),
      .res (prod)
   );

   mdu_cond_neg #(.W(W)) u_fix_quo (
      .val (acc[W-1:0]),
      .neg (sign_a ^ sign_b),
      .res (quo)
   );

   mdu_cond_neg #(.W(W)) u_fix_rem (
      .val (acc[2*W-1:W]),
      .neg (sign_a),
      .res (rem)
   );

   // Multiply keeps the multiplier in acc low half; divide keeps the
   // partial remainder in acc high half and shifts quotient bits in low.
   always_comb begin
      sum      = {1'b0, acc[2*W-1:W]} + {1'b0, opb};
      mul_next = acc[0] ? {sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
      shifted  = {acc[2*W-1:W], acc[W-1]};
      diff     = {1'b0, shifted} - {2'b00, opb};
      ge       = (diff[W+1:W] == 2'b00);
      div_next = ge ? {diff[W-1:0], acc[W-2:0], 1'b1}
                    : {shifted[W-1:0], acc[W-2:0], 1'b0};
   end

   always_comb begin
      res_lo = prod[W-1:0];
      res_hi = prod[2*W-1:W];
      if (is_div) begin
         res_lo = dz ? '1 : quo;
         res_hi = rem;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         op_q        <= MDU_MULT;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         dz          <= 1'b0;
         count       <= '0;
         opb         <= '0;
         acc         <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         lo          <= '0;
         hi          <= '0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start && !flush) begin
                  op_q   <= mdu_op_e'(op);
                  sign_a <= signed_in && rs_data[W-1];
                  sign_b <= signed_in && rt_data[W-1];
                  dz     <= op[1] && (rt_data == '0);
                  opb    <= mag_b;
                  acc    <= {{W{1'b0}}, mag_a};
                  count  <= CW'(WIDTH);
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               if (flush) begin
                  state <= S_IDLE;
               end else begin
                  acc   <= is_div ? div_next : mul_next;
                  count <= count - CW'(1);
                  if (count == CW'(1)) state <= S_FIX;
               end
            end
            S_FIX: begin
               state <= S_IDLE;
               if (!flush) begin
                  lo          <= res_lo;
                  hi          <= res_hi;
                  done        <= 1'b1;
                  div_by_zero <= dz;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] lo;
   logic [31:0] hi;
   logic        div_by_zero;

   int nchk  = 0;
   int npass = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .flush       (flush),
      .busy        (busy),
      .done        (done),
      .lo          (lo),
      .hi          (hi),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] elo,
                        output logic [31:0] ehi, output logic edz);
      longint sa, sb, sp, sq, sr;
      logic [63:0] ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      edz = 1'b0;
      case (o)
         2'b00: begin
            sp = sa * sb;
            elo = sp[31:0];
            ehi = sp[63:32];
         end
         2'b01: begin
            up = ua * ub;
            elo = up[31:0];
            ehi = up[63:32];
         end
         2'b10: begin
            if (b == 32'd0) begin
               elo = 32'hFFFF_FFFF; ehi = a; edz = 1'b1;
            end else begin
               sq = sa / sb;
               sr = sa % sb;
               elo = sq[31:0];
               ehi = sr[31:0];
            end
         end
         default: begin
            if (b == 32'd0) begin
               elo = 32'hFFFF_FFFF; ehi = a; edz = 1'b1;
            end else begin
               elo = 32'(ua / ub);
               ehi = 32'(ua % ub);
            end
         end
      endcase
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_check(input string tag, input logic [1:0] o,
                            input logic [31:0] a, input logic [31:0] b);
      logic [31:0] elo, ehi, plo, phi;
      logic edz;
      int n, nbusy;
      bit early;
      model(o, a, b, elo, ehi, edz);
      plo = lo;
      phi = hi;
      issue(o, a, b);
      n = 0; nbusy = 0; early = 0;
      while (!done && n < 40) begin
         if (busy) nbusy++;
         if (lo !== plo || hi !== phi || div_by_zero) early = 1;
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, ".latency"}, n, 33);
      check({tag, ".busy_cycles"}, nbusy, 33);
      check({tag, ".busy_at_done"}, busy, 0);
      check({tag, ".early_change"}, early, 0);
      check({tag, ".lo"}, lo, elo);
      check({tag, ".hi"}, hi, ehi);
      check({tag, ".dz"}, div_by_zero, edz);
   endtask

   initial begin
      logic [31:0] plo, phi, a, b;
      logic [1:0] o;
      int ndone;
      rst_n = 1'b0; start = 1'b0; flush = 1'b0;
      op = 2'b00; rs_data = '0; rt_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.busy", busy, 0);
      check("reset.done", done, 0);
      check("reset.lo", lo, 0);
      check("reset.hi", hi, 0);
      check("reset.dz", div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_check("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_check("mult_neg", 2'b00, -32'sd3, 32'sd7);
      run_check("div_neg", 2'b10, -32'sd7, 32'sd2);
      run_check("divu", 2'b11, 32'd7, 32'd2);
      run_check("divu_zero", 2'b11, 32'd100, 32'd0);
      run_check("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      run_check("div_zero_neg", 2'b10, 32'hFFFF_FFF0, 32'd0);
      @(posedge clk);
      #1;
      check("dz_pulse_len", div_by_zero, 0);
      check("done_pulse_len", done, 0);

      // flush mid-run, with an ignored start while busy
      plo = lo; phi = hi; ndone = 0;
      issue(2'b01, 32'd5, 32'd6);
      repeat (4) @(posedge clk);
      issue(2'b01, 32'd9, 32'd9);
      check("busy_start.busy", busy, 1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush.busy", busy, 0);
      repeat (40) begin
         if (done) ndone++;
         @(posedge clk);
         #1;
      end
      check("flush.no_done", ndone, 0);
      check("flush.lo", lo, plo);
      check("flush.hi", hi, phi);

      // flush in the sign-fix cycle
      issue(2'b00, 32'd11, 32'd13);
      repeat (32) @(posedge clk);
      #1;
      check("fixflush.busy_pre", busy, 1);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("fixflush.done", done, 0);
      check("fixflush.busy", busy, 0);
      check("fixflush.lo", lo, plo);

      // start together with flush in IDLE issues nothing
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 2'b01;
      rs_data = 32'd3; rt_data = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0; flush = 1'b0;
      check("idle_flush.busy", busy, 0);

      // async reset mid-divide
      run_check("pre_reset", 2'b01, 32'd1234, 32'd5678);
      issue(2'b10, 32'd1000, 32'd7);
      repeat (19) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset.busy", busy, 0);
      check("midreset.done", done, 0);
      check("midreset.lo", lo, 0);
      check("midreset.hi", hi, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_check("post_reset", 2'b01, 32'd2, 32'd3);

      for (int i = 0; i < 24; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         run_check($sformatf("rand%0d", i), o, a, b);
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
